// File: rtl/count_stream_checker_pkg.sv
// ============================================================================
//  Module  : count_stream_checker_pkg
//  Brief   : Shared state encoding and default sizing for the stream checker.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package count_stream_checker_pkg;

    localparam int c_default_w           = 4;
    localparam int c_default_lock_cycles = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/count_stream_checker_if.sv
// ============================================================================
//  Module  : count_stream_checker_if
//  Brief   : Dual-counter stream bus (enable, up-count, down-count).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface count_stream_checker_if #(
    parameter int W = count_stream_checker_pkg::c_default_w
) ();

    logic         enable;
    logic [W-1:0] count1_in;
    logic [W-1:0] count2_in;

    modport master (output enable, output count1_in, output count2_in);
    modport slave  (input  enable, input  count1_in, input  count2_in);

endinterface

`default_nettype wire

// File: rtl/count_stream_checker_step_predictor.sv
// ============================================================================
//  Module  : count_stream_checker_step_predictor
//  Brief   : Holds the next expected up/down counter values and flags a match.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module count_stream_checker_step_predictor #(
    parameter int W = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         load,
    input  wire logic         advance,
    input  wire logic [W-1:0] count1_in,
    input  wire logic [W-1:0] count2_in,
    output logic              match
);

    logic [W-1:0] r_exp1;
    logic [W-1:0] r_exp2;

    // Modulo-2^W arithmetic makes counter wrap-around a normal step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp1 <= '0;
            r_exp2 <= '0;
        end else if (load) begin
            r_exp1 <= count1_in + W'(1);
            r_exp2 <= count2_in - W'(1);
        end else if (advance) begin
            r_exp1 <= r_exp1 + W'(1);
            r_exp2 <= r_exp2 - W'(1);
        end
    end

    assign match = (count1_in == r_exp1) && (count2_in == r_exp2);

endmodule

`default_nettype wire

// File: rtl/count_stream_checker.sv
// ============================================================================
//  Module  : count_stream_checker
//  Brief   : Learns and verifies a dual up/down counter stream; optional
//            complement check enabled by COUNT_CHECK_COMPLEMENT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module count_stream_checker
    import count_stream_checker_pkg::*;
#(
    parameter int W           = c_default_w,
    parameter int LOCK_CYCLES = c_default_lock_cycles,
    parameter int ERR_W       = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    count_stream_checker_if.slave bus,
    output logic                  locked,
    output logic                  mismatch,
    output logic [ERR_W-1:0]      err_count,
    output logic [1:0]            state_o
);

    localparam logic [4:0]       c_lock_target = 5'(LOCK_CYCLES);
    localparam logic [ERR_W-1:0] c_err_one     = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_run, w_run_nxt;
    logic             r_locked, w_locked_nxt;
    logic             r_mismatch, w_mismatch_nxt;
    logic [ERR_W-1:0] r_err, w_err_nxt;
    logic             w_load, w_advance;
    logic             w_seq_match, w_comp_ok, w_hit;
    logic [4:0]       w_run_inc;

    count_stream_checker_step_predictor #(.W(W)) u_predictor (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .advance   (w_advance),
        .count1_in (bus.count1_in),
        .count2_in (bus.count2_in),
        .match     (w_seq_match)
    );

`ifdef COUNT_CHECK_COMPLEMENT_EN
    assign w_comp_ok = (bus.count2_in == ~bus.count1_in);
`else
    assign w_comp_ok = 1'b1;
`endif

    assign w_hit     = w_seq_match && w_comp_ok;
    assign w_run_inc = {1'b0, r_run} + 5'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_run      <= '0;
            r_locked   <= 1'b0;
            r_mismatch <= 1'b0;
            r_err      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_run      <= w_run_nxt;
            r_locked   <= w_locked_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_run_nxt      = r_run;
        w_locked_nxt   = r_locked;
        w_mismatch_nxt = 1'b0;
        w_err_nxt      = r_err;
        w_load         = 1'b0;
        w_advance      = 1'b0;

        if (bus.enable) begin
            unique case (r_state)
                IDLE: begin
                    if (w_comp_ok) begin
                        w_load      = 1'b1;
                        w_run_nxt   = '0;
                        w_state_nxt = SEED;
                    end
                end
                SEED, TRACK: begin
                    // Acquisition: misses only reseed, they are not reported.
                    if (w_hit) begin
                        w_advance = 1'b1;
                        w_run_nxt = w_run_inc[3:0];
                        if (w_run_inc >= c_lock_target) begin
                            w_state_nxt  = LOCKED;
                            w_locked_nxt = 1'b1;
                        end else begin
                            w_state_nxt = TRACK;
                        end
                    end else begin
                        w_load      = 1'b1;
                        w_run_nxt   = '0;
                        w_state_nxt = SEED;
                    end
                end
                LOCKED: begin
                    if (w_hit) begin
                        w_advance = 1'b1;
                    end else begin
                        w_load         = 1'b1;
                        w_run_nxt      = '0;
                        w_locked_nxt   = 1'b0;
                        w_mismatch_nxt = 1'b1;
                        w_state_nxt    = SEED;
                        if (r_err != '1) begin
                            w_err_nxt = r_err + c_err_one;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign locked    = r_locked;
    assign mismatch  = r_mismatch;
    assign err_count = r_err;
    assign state_o   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_count_stream_checker.sv
// ============================================================================
//  Module  : tb_count_stream_checker
//  Brief   : Directed self-checking bench for count_stream_checker (W=4).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_count_stream_checker;

    logic       clk;
    logic       reset;
    logic       locked;
    logic       mismatch;
    logic [7:0] err_count;
    logic [1:0] state_o;

    int n_checks;
    int n_errors;
    int c1;     // current up-count value
    int k;      // count2 is driven as (k - c1) mod 16
    int exp_err;

    count_stream_checker_if #(.W(4)) bus ();

    count_stream_checker #(.W(4), .LOCK_CYCLES(4), .ERR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .locked    (locked),
        .mismatch  (mismatch),
        .err_count (err_count),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input bit en, input int a, input int b);
        @(negedge clk);
        bus.enable    = en;
        bus.count1_in = 4'(a);
        bus.count2_in = 4'(b);
        @(posedge clk);
        #1;
    endtask

    // Next correct sample of the running sequence.
    task automatic good_step();
        c1 = (c1 + 1) % 16;
        step(1'b1, c1, (k - c1) & 15);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.count1_in = '0;
        bus.count2_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_locked",   locked,    0);
        check("reset_mismatch", mismatch,  0);
        check("reset_err",      err_count, 0);
        check("reset_state",    state_o,   0);
        @(negedge clk);
        reset = 1'b0;

        // Up/down lock: seed at 0/15, four matches -> locked
        k = 15;
        c1 = 0;
        step(1'b1, 0, 15);
        check("seed_state", state_o, 1);
        good_step();
        check("track_state", state_o, 2);
        good_step();
        good_step();
        check("prelock_locked", locked, 0);
        good_step();
        check("lock_locked", locked, 1);
        check("lock_state",  state_o, 3);
        good_step();
        check("lock_hold",     locked,    1);
        check("lock_mismatch", mismatch,  0);
        check("lock_err",      err_count, 0);

        // Wrap through 14,15,0,1 while locked
        while (c1 != 13) good_step();
        repeat (4) begin
            good_step();
            check("wrap_locked",   locked,   1);
            check("wrap_mismatch", mismatch, 0);
        end
        check("wrap_c1", c1, 1);

        // Skip error: locked at 6, jump to 8
        while (c1 != 6) good_step();
        check("pre_skip_locked", locked, 1);
`ifdef COUNT_CHECK_COMPLEMENT_EN
        step(1'b1, 8, 7);
`else
        step(1'b1, 8, 8);
        k = 0;
`endif
        c1 = 8;
        check("skip_mismatch", mismatch,  1);
        check("skip_err",      err_count, 1);
        check("skip_locked",   locked,    0);
        check("skip_state",    state_o,   1);
        good_step();
        check("skip_pulse_end", mismatch, 0);
        good_step();
        good_step();
        check("relock_early", locked, 0);
        good_step();
        check("relock", locked, 1);

        // Enable gap with random bus activity
        repeat (3) begin
            step(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            check("gap_mismatch", mismatch, 0);
            check("gap_locked",   locked,   1);
            check("gap_state",    state_o,  3);
        end
        good_step();
        check("gap_resume_locked",   locked,   1);
        check("gap_resume_mismatch", mismatch, 0);

        // Saturation: 300 locked-state errors, relocking between each
        exp_err = 1;
        for (int i = 0; i < 300; i++) begin
            c1 = (c1 + 2) % 16;
            step(1'b1, c1, (k - c1) & 15);
            if (exp_err < 255) exp_err++;
            check("sat_mismatch", mismatch,  1);
            check("sat_err",      err_count, exp_err);
            repeat (4) good_step();
            check("sat_relock", locked, 1);
        end
        check("sat_final", err_count, 255);

        do_reset();
        check("rst2_err",    err_count, 0);
        check("rst2_locked", locked,    0);
        check("rst2_state",  state_o,   0);

        // Enable low in IDLE: no seeding
        step(1'b0, 5, 10);
        check("idle_hold", state_o, 0);

        // Miss on the edge that would reach LOCK_CYCLES: stays unlocked, silent
        k = 15;
        c1 = 2;
        step(1'b1, 2, 13);
        good_step();
        good_step();
        good_step();
        c1 = 9;
        step(1'b1, 9, 6);
        check("edge_locked",   locked,    0);
        check("edge_state",    state_o,   1);
        check("edge_mismatch", mismatch,  0);
        check("edge_err",      err_count, 0);

`ifdef COUNT_CHECK_COMPLEMENT_EN
        do_reset();
        step(1'b1, 3, 7);
        check("comp_idle_hold", state_o, 0);
        c1 = 3;
        step(1'b1, 3, 12);
        check("comp_seed", state_o, 1);
        repeat (4) good_step();
        check("comp_locked", locked, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
- Consumer side of the dual-counter interface (enable, count1 up-count, count2 down-count).
- Samples both count buses every clock and learns the sequence from them.
- Declares lock after a run of correct steps, then flags any deviation: skip, stall while enabled, wrong direction, or corruption.
- Sits beside the counter producer as an in-design health monitor; the verification bench also uses it as a scoreboard.

Parameters:
- W, 4, width of count1/count2 buses.
- LOCK_CYCLES, 4, consecutive correct enabled steps required to assert locked (range 1..15).
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  producer enable; high means the counters advance this cycle.
- count1_in  input  W  producer up-counter value.
- count2_in  input  W  producer down-counter value.
- locked  output  1  sequence tracked and verified.
- mismatch  output  1  one-cycle pulse on a detected error.
- err_count  output  ERR_W  saturating count of mismatches since reset.
- state_o  output  2  current FSM state, for debug.

Behaviour:
- Reset values:
  - Synchronous on reset=1 at a clk edge.
  - locked=0, mismatch=0, err_count=0, state=IDLE, match run counter=0, expected registers=0.
- Sampling: count1_in, count2_in and enable are sampled together on every rising edge.
- FSM states: IDLE=0, SEED=1, TRACK=2, LOCKED=3.
- IDLE:
  - Leaves on the first edge with enable=1 and goes to SEED.
  - Stores exp1 = count1_in+1 and exp2 = count2_in-1, both modulo 2^W.
- SEED and TRACK, enable=1:
  - Compare: count1_in==exp1 AND count2_in==exp2.
  - On match: run+1, then exp1+=1 and exp2-=1.
  - On mismatch: run=0, reseed exp1/exp2 from the current inputs, state SEED.
  - No mismatch pulse and no err_count change before the first lock (acquisition only).
- SEED goes to TRACK after its first match.
- TRACK goes to LOCKED when run reaches LOCK_CYCLES.
  - locked=1 from the edge that makes run==LOCK_CYCLES.
  - So LOCK_CYCLES matches after the seed sample, locked is visible in the following cycle.
- LOCKED, enable=1:
  - On match: advance exp1/exp2 and stay.
  - On mismatch: mismatch=1 for exactly one cycle (the cycle after the offending sample), err_count+1 saturating at 2^ERR_W-1, locked=0, run=0, reseed from the current inputs, state SEED.
- enable=0 in any state:
  - No comparison; exp1, exp2, run and state hold.
  - Input changes while enable=0 are ignored.
- Wrap-around is legal and is not an error: count1 2^W-1 → 0; count2 0 → 2^W-1.
- Comparisons use unsigned modulo-2^W arithmetic only.
- Simultaneous events:
  - reset has priority over everything.
  - A mismatch on the edge where run would reach LOCK_CYCLES resolves as a mismatch; locked stays 0.
- Reset mid-operation: returns to IDLE and clears err_count; the next enabled sample reseeds.
- err_count is never cleared except by reset.

Optional Feature:
- Macro: COUNT_CHECK_COMPLEMENT_EN.
- Defined:
  - Each enabled compare also requires count2_in == ~count1_in (bitwise, W bits).
  - A violation is treated exactly like a sequence mismatch.
  - The seed sample in IDLE must also satisfy the relation, otherwise IDLE is held.
- Undefined:
  - count1 and count2 are checked independently.
  - No relation between the two buses is enforced.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE/SEED/TRACK/LOCKED (2-bit typedef).
  - Default W and default LOCK_CYCLES.
- Natural sub-module: step_predictor.
  - Holds exp1/exp2.
  - Load/advance controls and modulo arithmetic.
  - Combinational match output.
- FSM and error counter stay in the top level.

Test Plan (W=4, LOCK_CYCLES=4):
- Up/down lock: reset, then enable=1 with count1 0,1,2,3,4,5 and count2 15,14,13,12,11,10 → locked=1 after the 5th sample, mismatch never asserted, err_count=0.
- Wrap: once locked, drive count1 14,15,0,1 with count2 1,0,15,14 → locked stays 1, no mismatch.
- Skip error: once locked at count1=6, drive count1=8 (count2 correct) → mismatch pulses once, err_count=1, locked=0; relock 4 samples later.
- Enable gap: once locked, hold enable=0 for 3 cycles while count buses toggle randomly, then resume the correct sequence → no mismatch, locked stays 1.
- Saturation and reset: inject 300 locked-state errors (relock between each) with ERR_W=8 → err_count stops at 255; reset=1 for one cycle → err_count=0, locked=0, state_o=0.
- Complement (macro defined): seed count1=3, count2=7 → FSM stays IDLE; count1=3, count2=12 → seeds and locks normally.
